// File: rtl/acc_seq_core.sv
// Accumulator sequencer: loads a program into instruction memory, then fetches and executes it two cycles per instruction.
// Optional multiplier for MULI is enabled by defining ACC_SEQ_MULI_EN; otherwise opcode 12 is illegal.
module acc_seq_core #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int INSN_W = 5 + DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [ADDR_W-1:0] address,
   input  logic [INSN_W-1:0] data_in,
   input  logic              start,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] pc_debug,
   output logic [INSN_W-1:0] rc_debug,
   output logic [4:0]        op_code_debug,
   output logic              busy,
   output logic              halted,
   output logic              illegal
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_MOVI = 5'd1;
   localparam logic [4:0] OP_ADDI = 5'd2;
   localparam logic [4:0] OP_SUBI = 5'd3;
   localparam logic [4:0] OP_ANDI = 5'd4;
   localparam logic [4:0] OP_ORI  = 5'd5;
   localparam logic [4:0] OP_XORI = 5'd6;
   localparam logic [4:0] OP_NOT  = 5'd7;
   localparam logic [4:0] OP_SHL  = 5'd8;
   localparam logic [4:0] OP_SHR  = 5'd9;
   localparam logic [4:0] OP_INC  = 5'd10;
   localparam logic [4:0] OP_DEC  = 5'd11;
`ifdef ACC_SEQ_MULI_EN
   localparam logic [4:0] OP_MULI = 5'd12;
`endif
   localparam logic [4:0] OP_HALT = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } state_t;

   state_t            state_reg;
   logic [INSN_W-1:0] imem [DEPTH];
   logic [ADDR_W-1:0] pc_reg;
   logic [INSN_W-1:0] ir_reg;
   logic [DATA_W-1:0] acc_reg;
   logic              busy_reg;
   logic              halted_reg;
   logic              illegal_reg;

   logic [4:0]        opcode;
   logic [DATA_W-1:0] imm;
   logic [SH_W-1:0]   shamt;
   logic [DATA_W-1:0] acc_next;
   logic              op_known;
   logic              op_halt;
   logic              pc_last;
   logic              mem_we;

   assign opcode  = ir_reg[INSN_W-1 -: 5];
   assign imm     = ir_reg[DATA_W-1:0];
   assign shamt   = imm[SH_W-1:0];
   assign pc_last = (pc_reg == ADDR_W'(DEPTH - 1));

   // Program loading is only accepted while the core is not running.
   assign mem_we  = wr && !reset && ((state_reg == ST_IDLE) || (state_reg == ST_HALT));

   always_comb begin
      acc_next = acc_reg;
      op_known = 1'b1;
      op_halt  = 1'b0;
      case (opcode)
         OP_NOP:  acc_next = acc_reg;
         OP_MOVI: acc_next = imm;
         OP_ADDI: acc_next = acc_reg + imm;
         OP_SUBI: acc_next = acc_reg - imm;
         OP_ANDI: acc_next = acc_reg & imm;
         OP_ORI:  acc_next = acc_reg | imm;
         OP_XORI: acc_next = acc_reg ^ imm;
         OP_NOT:  acc_next = ~acc_reg;
         OP_SHL:  acc_next = acc_reg << shamt;
         OP_SHR:  acc_next = acc_reg >> shamt;
         OP_INC:  acc_next = acc_reg + DATA_W'(1);
         OP_DEC:  acc_next = acc_reg - DATA_W'(1);
`ifdef ACC_SEQ_MULI_EN
         OP_MULI: acc_next = acc_reg * imm;
`endif
         OP_HALT: op_halt  = 1'b1;
         default: op_known = 1'b0;
      endcase
   end

   // Memory has no reset so a program survives a core reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         imem[address] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         pc_reg      <= '0;
         ir_reg      <= '0;
         acc_reg     <= '0;
         busy_reg    <= 1'b0;
         halted_reg  <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  pc_reg      <= '0;
                  illegal_reg <= 1'b0;
                  busy_reg    <= 1'b1;
                  halted_reg  <= 1'b0;
                  state_reg   <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               ir_reg    <= imem[pc_reg];
               state_reg <= ST_EXEC;
            end
            ST_EXEC: begin
               if (op_halt || !op_known) begin
                  illegal_reg <= illegal_reg | !op_known;
                  busy_reg    <= 1'b0;
                  halted_reg  <= 1'b1;
                  state_reg   <= ST_HALT;
               end else begin
                  acc_reg <= acc_next;
                  // The last word executes, then the core stops without wrapping pc.
                  if (pc_last) begin
                     busy_reg   <= 1'b0;
                     halted_reg <= 1'b1;
                     state_reg  <= ST_HALT;
                  end else begin
                     pc_reg    <= pc_reg + ADDR_W'(1);
                     state_reg <= ST_FETCH;
                  end
               end
            end
            default: begin
               busy_reg   <= 1'b0;
               halted_reg <= 1'b0;
               state_reg  <= ST_IDLE;
            end
         endcase
      end
   end

   assign data_out      = acc_reg;
   assign pc_debug      = pc_reg;
   assign rc_debug      = ir_reg;
   assign op_code_debug = opcode;
   assign busy          = busy_reg;
   assign halted        = halted_reg;
   assign illegal       = illegal_reg;

endmodule

// File: tb/tb_acc_seq_core.sv
// Directed bench for acc_seq_core: default-size core plus a DEPTH=4 instance for end-of-memory and mid-run reset cases.
module tb_acc_seq_core;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, wr, start;
   logic [5:0]  address;
   logic [36:0] data_in;
   logic [31:0] data_out;
   logic [5:0]  pc_debug;
   logic [36:0] rc_debug;
   logic [4:0]  op_code_debug;
   logic        busy, halted, illegal;

   logic        reset4, wr4, start4;
   logic [1:0]  address4;
   logic [36:0] data_in4;
   logic [31:0] data_out4;
   logic [1:0]  pc_debug4;
   logic [36:0] rc_debug4;
   logic [4:0]  op_code_debug4;
   logic        busy4, halted4, illegal4;

   int tests_run    = 0;
   int tests_failed = 0;

   acc_seq_core dut (
      .clk(clk), .reset(reset), .wr(wr), .address(address), .data_in(data_in),
      .start(start), .data_out(data_out), .pc_debug(pc_debug), .rc_debug(rc_debug),
      .op_code_debug(op_code_debug), .busy(busy), .halted(halted), .illegal(illegal)
   );

   acc_seq_core #(.DEPTH(4)) dut4 (
      .clk(clk), .reset(reset4), .wr(wr4), .address(address4), .data_in(data_in4),
      .start(start4), .data_out(data_out4), .pc_debug(pc_debug4), .rc_debug(rc_debug4),
      .op_code_debug(op_code_debug4), .busy(busy4), .halted(halted4), .illegal(illegal4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, got);
      end
   endtask

   function automatic logic [36:0] ins(input logic [4:0] op, input logic [31:0] imm);
      return {op, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load(input logic [5:0] a, input logic [36:0] w);
      wr = 1'b1; address = a; data_in = w;
      tick();
      wr = 1'b0;
   endtask

   task automatic load4(input logic [1:0] a, input logic [36:0] w);
      wr4 = 1'b1; address4 = a; data_in4 = w;
      tick();
      wr4 = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_until_halt(input string tag, input int max_cycles);
      int n = 0;
      while (!halted && n < max_cycles) begin
         tick();
         n++;
      end
      check(tag, {63'd0, halted}, 64'd1);
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; start = 1'b0; address = '0; data_in = '0;
      reset4 = 1'b1; wr4 = 1'b0; start4 = 1'b0; address4 = '0; data_in4 = '0;
      tick_n(2);
      reset = 1'b0; reset4 = 1'b0;
      check("rst_data", data_out, 0);
      check("rst_pc", pc_debug, 0);
      check("rst_rc", rc_debug, 0);
      check("rst_op", op_code_debug, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_illegal", illegal, 0);

      // MOVI 5, ADDI 3, SUBI 1, HALT
      load(0, ins(5'd1, 32'd5));
      load(1, ins(5'd2, 32'd3));
      load(2, ins(5'd3, 32'd1));
      load(3, ins(5'd31, 32'd0));
      pulse_start();
      check("p1_busy_after_start", busy, 1);
      tick_n(2);
      check("p1_movi", data_out, 5);
      check("p1_ir", rc_debug, ins(5'd1, 32'd5));
      check("p1_opcode", op_code_debug, 1);
      check("p1_pc", pc_debug, 1);
      tick_n(2);
      check("p1_addi", data_out, 8);
      tick_n(2);
      check("p1_subi", data_out, 7);
      tick();
      check("p1_halted_cycle7", halted, 0);
      tick();
      check("p1_halted_cycle8", halted, 1);
      check("p1_busy_end", busy, 0);
      check("p1_data", data_out, 7);
      check("p1_pc_end", pc_debug, 3);
      check("p1_illegal", illegal, 0);

      // MOVI 0, DEC, HALT; a write during FETCH and a start during EXEC must be ignored
      load(0, ins(5'd1, 32'd0));
      load(1, ins(5'd11, 32'd0));
      load(2, ins(5'd31, 32'd0));
      pulse_start();
      wr = 1'b1; address = 6'd2; data_in = ins(5'd1, 32'd9);
      tick();
      wr = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick_n(3);
      check("p2_halted_cycle5", halted, 0);
      tick();
      check("p2_halted_cycle6", halted, 1);
      check("p2_dec_wrap", data_out, 32'hFFFF_FFFF);

      // MOVI 1, SHL 31, SHR 31, NOT, HALT
      load(0, ins(5'd1, 32'd1));
      load(1, ins(5'd8, 32'd31));
      load(2, ins(5'd9, 32'd31));
      load(3, ins(5'd7, 32'd0));
      load(4, ins(5'd31, 32'd0));
      pulse_start();
      tick_n(4);
      check("p3_shl", data_out, 32'h8000_0000);
      tick_n(2);
      check("p3_shr", data_out, 1);
      tick_n(2);
      check("p3_not", data_out, 32'hFFFF_FFFE);
      run_until_halt("p3_halted", 10);

      // Logic ops, shift using only imm[4:0], modulo add/sub
      load(0, ins(5'd1, 32'hF0));
      load(1, ins(5'd4, 32'h3C));
      load(2, ins(5'd5, 32'h101));
      load(3, ins(5'd6, 32'hFF));
      load(4, ins(5'd8, 32'h21));
      load(5, ins(5'd10, 32'd0));
      load(6, ins(5'd2, 32'hFFFF_FFFF));
      load(7, ins(5'd0, 32'd0));
      load(8, ins(5'd3, 32'h39D));
      load(9, ins(5'd31, 32'd0));
      pulse_start();
      tick_n(12);
      check("p4_mid", data_out, 32'h39D);
      run_until_halt("p4_halted", 40);
      check("p4_final", data_out, 32'hFFFF_FFFF);
      check("p4_pc", pc_debug, 9);

      // MOVI 6, MULI 7, HALT
      load(0, ins(5'd1, 32'd6));
      load(1, ins(5'd12, 32'd7));
      load(2, ins(5'd31, 32'd0));
      pulse_start();
      run_until_halt("p5_halted", 20);
`ifdef ACC_SEQ_MULI_EN
      check("p5_muli", data_out, 42);
      check("p5_illegal", illegal, 0);
`else
      check("p5_muli", data_out, 6);
      check("p5_illegal", illegal, 1);
`endif

      // Reset keeps memory: rerun same program without reloading
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("p6_rst_data", data_out, 0);
      check("p6_rst_illegal", illegal, 0);
      check("p6_rst_halted", halted, 0);
      pulse_start();
      run_until_halt("p6_halted", 20);
`ifdef ACC_SEQ_MULI_EN
      check("p6_rerun", data_out, 42);
`else
      check("p6_rerun", data_out, 6);
`endif

      // Illegal opcode 20 from a fresh reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      load(0, ins(5'd20, 32'h123));
      pulse_start();
      tick_n(2);
      check("p7_halted", halted, 1);
      check("p7_illegal", illegal, 1);
      check("p7_data", data_out, 0);
      check("p7_opcode", op_code_debug, 20);
      check("p7_pc", pc_debug, 0);
      load(0, ins(5'd1, 32'd3));
      load(1, ins(5'd31, 32'd0));
      check("p7_illegal_sticky", illegal, 1);
      pulse_start();
      check("p7_illegal_cleared", illegal, 0);
      run_until_halt("p8_halted", 10);
      check("p8_data", data_out, 3);

      // DEPTH=4: four NOPs run off the end of memory
      for (int i = 0; i < 4; i++) load4(2'(i), ins(5'd0, 32'd0));
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick_n(7);
      check("d4_halted_cycle7", halted4, 0);
      tick();
      check("d4_halted_cycle8", halted4, 1);
      check("d4_pc", pc_debug4, 3);
      check("d4_data", data_out4, 0);
      check("d4_illegal", illegal4, 0);

      // DEPTH=4: MOVI 2, INC x3; reset mid-run then restart
      load4(0, ins(5'd1, 32'd2));
      load4(1, ins(5'd10, 32'd0));
      load4(2, ins(5'd10, 32'd0));
      load4(3, ins(5'd10, 32'd0));
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick_n(3);
      check("d4_midrun_busy", busy4, 1);
      check("d4_midrun_data", data_out4, 2);
      reset4 = 1'b1;
      tick();
      reset4 = 1'b0;
      check("d4_rst_data", data_out4, 0);
      check("d4_rst_pc", pc_debug4, 0);
      check("d4_rst_rc", rc_debug4, 0);
      check("d4_rst_op", op_code_debug4, 0);
      check("d4_rst_busy", busy4, 0);
      check("d4_rst_halted", halted4, 0);
      check("d4_rst_illegal", illegal4, 0);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick_n(8);
      check("d4_rerun_halted", halted4, 1);
      check("d4_rerun_pc", pc_debug4, 3);
      check("d4_rerun_data", data_out4, 5);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/acc_seq_core.md
ACC_SEQ_CORE -- requirements
Module: acc_seq_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32: accumulator and immediate width.
REQ-002 SHALL have parameter DEPTH, default 64: instruction memory words; ADDR_W = $clog2(DEPTH), derived.
REQ-003 SHALL use instruction word {opcode[4:0], imm[DATA_W-1:0]}, width 5+DATA_W.
REQ-004 SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 wr  in  1  load strobe: writes data_in to imem[address].
REQ-008 address  in  ADDR_W  load address.
REQ-009 data_in  in  5+DATA_W  instruction word to load.
REQ-010 start  in  1  one-cycle pulse that begins execution at address 0.
REQ-011 data_out  out  DATA_W  accumulator.
REQ-012 pc_debug  out  ADDR_W  program counter.
REQ-013 rc_debug  out  5+DATA_W  instruction register.
REQ-014 op_code_debug  out  5  opcode field of instruction register.
REQ-015 busy  out  1  high in FETCH or EXEC.
REQ-016 halted  out  1  high in HALT.
REQ-017 illegal  out  1  sticky: illegal opcode executed.

Function
REQ-018 SHALL implement FSM IDLE, FETCH, EXEC, HALT.
REQ-019 IDLE: wr=1 writes imem[address] on that edge; start=1 clears pc and illegal, goes to FETCH; wr and start together: write occurs, then FETCH.
REQ-020 FETCH (1 cycle): IR <= imem[pc]; goto EXEC.
REQ-021 EXEC (1 cycle): update accumulator per opcode; pc <= pc+1; goto FETCH; two cycles per instruction.
REQ-022 Opcodes: 0 NOP, 1 MOVI acc=imm, 2 ADDI acc+imm, 3 SUBI acc-imm, 4 ANDI, 5 ORI, 6 XORI, 7 NOT ~acc, 8 SHL acc<<imm[log2 DATA_W-1:0], 9 SHR logical, 10 INC, 11 DEC, 12 MULI, 31 HALT.
REQ-023 Arithmetic SHALL be modulo 2^DATA_W: no saturation, no carry output; 0-1 wraps to all-ones.
REQ-024 HALT opcode: accumulator unchanged, pc unchanged, goto HALT.
REQ-025 Any other opcode SHALL set illegal, leave the accumulator unchanged and goto HALT.
REQ-026 EXEC at pc=DEPTH-1 with a non-HALT opcode SHALL execute, then goto HALT with pc held at DEPTH-1: no wrap.
REQ-027 HALT: outputs hold; start=1 restarts as from IDLE; wr=1 writes memory.
REQ-028 wr SHALL be ignored in FETCH and EXEC; start SHALL be ignored in FETCH and EXEC.
REQ-029 data_out SHALL update on the EXEC edge and be visible the following cycle.

Reset
REQ-030 reset=1 SHALL force IDLE on the next edge from any state, including mid-program.
REQ-031 After reset: data_out=0, pc_debug=0, rc_debug=0, op_code_debug=0, busy=0, halted=0, illegal=0.
REQ-032 Instruction memory contents SHALL NOT be cleared by reset.

Configuration
REQ-033 Macro ACC_SEQ_MULI_EN defined: opcode 12 computes the low DATA_W bits of acc*imm in one EXEC cycle.
REQ-034 Macro undefined: no multiplier is synthesised and opcode 12 is handled as illegal (REQ-025).

Verification
REQ-035 Load [MOVI 5, ADDI 3, SUBI 1, HALT], start -> data_out=7, halted=1 exactly 8 cycles after start.
REQ-036 Load [MOVI 0, DEC, HALT] -> data_out=all-ones (0xFFFFFFFF at DATA_W=32).
REQ-037 Load [MOVI 1, SHL 31, SHR 31, NOT, HALT] -> after SHL data_out=0x80000000; final data_out=0xFFFFFFFE.
REQ-038 Load [MOVI 6, MULI 7, HALT] -> with ACC_SEQ_MULI_EN: 42, illegal=0; without: 6, illegal=1, halted=1.
REQ-039 DEPTH=4, load four NOPs, start -> halted=1, pc_debug=3; assert reset mid-run in a second run -> IDLE, all outputs 0, a restart reproduces the same results.
REQ-040 Load opcode 20 at address 0 -> illegal=1, halted=1, data_out=0; a following start clears illegal.
